// File: rtl/register_bank_mp.sv
// Multi-read-port register bank for the single-cycle MIPS datapath.
// After reset it sweeps zeros into every register before accepting writes.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_RESET | reset_n low or just released; reads return 0, writes ignored
//   S_CLEAR | one register zeroed per edge, clear_idx counts 0..DEPTH-1
//   S_READY | normal operation, flag_ready high
module register_bank_mp #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_READ    = 2,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_Regs,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_Regs,
    input  logic [ADDR_WIDTH-1:0]          write_Reg,
    input  logic [DATA_WIDTH-1:0]          write_Data,
    input  logic                           flag_RegWrite,
    input  logic [DATA_WIDTH-1:0]          address_PC,
    input  logic                           flag_Jal,
    output logic                           flag_ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    // LINK_REG is folded into the index range of this bank
    localparam logic [ADDR_WIDTH-1:0] LINK_IDX = ADDR_WIDTH'(LINK_REG);
    localparam logic [DATA_WIDTH-1:0] LINK_ADD = DATA_WIDTH'(LINK_OFFSET);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] clear_idx;
    logic [DATA_WIDTH-1:0] registers [DEPTH];

    logic                  link_we;
    logic                  main_we;
    logic [DATA_WIDTH-1:0] link_data;

    assign link_we   = (state == S_READY) && flag_Jal && (LINK_IDX != '0);
    assign main_we   = (state == S_READY) && flag_RegWrite && (write_Reg != '0);
    assign link_data = address_PC + LINK_ADD;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_RESET;
            clear_idx  <= '0;
            flag_ready <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    state     <= S_CLEAR;
                    clear_idx <= '0;
                end
                S_CLEAR: begin
                    clear_idx <= clear_idx + ADDR_WIDTH'(1);
                    if (clear_idx == LAST_IDX) begin
                        state      <= S_READY;
                        flag_ready <= 1'b1;
                    end
                end
                S_READY: begin
                    state <= S_READY;
                end
                default: begin
                    state      <= S_RESET;
                    clear_idx  <= '0;
                    flag_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the clear sweep provides the initial contents.
    // The main write is issued last so it wins a collision on LINK_IDX.
    always_ff @(posedge clock) begin
        if (state == S_CLEAR) begin
            registers[clear_idx] <= '0;
        end else begin
            if (link_we) begin
                registers[LINK_IDX] <= link_data;
            end
            if (main_we) begin
                registers[write_Reg] <= write_Data;
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0] rd_data;

        assign rd_addr = read_Regs[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_data = '0;
            if ((state == S_READY) && (rd_addr != '0)) begin
                if (main_we && (write_Reg == rd_addr)) begin
                    rd_data = write_Data;
                end else if (link_we && (LINK_IDX == rd_addr)) begin
                    rd_data = link_data;
                end else begin
                    rd_data = registers[rd_addr];
                end
            end
        end

        assign data_Regs[k*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    end

endmodule

// File: tb/tb_register_bank_mp.sv
// Bench for register_bank_mp: default 32x32/2-port bank (dut_a) and a
// 16x64/4-port bank (dut_b), checked against a scoreboard and a bench-side model.
module tb_register_bank_mp;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_a;
    logic [9:0]  rr_a;
    logic [63:0] dr_a;
    logic [4:0]  wr_a;
    logic [31:0] wd_a;
    logic        we_a;
    logic [31:0] pc_a;
    logic        jal_a;
    logic        rdy_a;

    logic         rst_b;
    logic [15:0]  rr_b;
    logic [255:0] dr_b;
    logic [3:0]   wr_b;
    logic [63:0]  wd_b;
    logic         we_b;
    logic [63:0]  pc_b;
    logic         jal_b;
    logic         rdy_b;

    register_bank_mp dut_a (
        .clock(clock), .reset_n(rst_a), .read_Regs(rr_a), .data_Regs(dr_a),
        .write_Reg(wr_a), .write_Data(wd_a), .flag_RegWrite(we_a),
        .address_PC(pc_a), .flag_Jal(jal_a), .flag_ready(rdy_a)
    );

    register_bank_mp #(
        .DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_READ(4), .LINK_REG(15), .LINK_OFFSET(1)
    ) dut_b (
        .clock(clock), .reset_n(rst_b), .read_Regs(rr_b), .data_Regs(dr_b),
        .write_Reg(wr_b), .write_Data(wd_b), .flag_RegWrite(we_b),
        .address_PC(pc_b), .flag_Jal(jal_b), .flag_ready(rdy_b)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;

    sb_t         sb[$];
    int          passes = 0;
    int          total  = 0;
    int          fails  = 0;
    logic [63:0] mdl [2][32];

    task automatic push(input string tag, input logic [63:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        sb_t e;
        total++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [63:0] lane(input bit sel, input int k);
        if (sel) return dr_b[k*64 +: 64];
        return {32'b0, dr_a[k*32 +: 32]};
    endfunction

    function automatic logic ready(input bit sel);
        return sel ? rdy_b : rdy_a;
    endfunction

    function automatic int depth(input bit sel);
        return sel ? 16 : 32;
    endfunction

    function automatic int lanes(input bit sel);
        return sel ? 4 : 2;
    endfunction

    function automatic int link_idx(input bit sel);
        return sel ? 15 : 31;
    endfunction

    function automatic logic [63:0] mask(input bit sel);
        return sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Value a read of idx must show while the given writes are pending.
    function automatic logic [63:0] ref_read(input bit sel, input int idx, input bit we,
                                             input int wr, input logic [63:0] wd,
                                             input bit jal, input logic [63:0] pc);
        if (idx == 0) return 64'h0;
        if (we && wr == idx) return wd & mask(sel);
        if (jal && idx == link_idx(sel)) return (pc + 64'd1) & mask(sel);
        return mdl[sel][idx];
    endfunction

    task automatic drive(input bit sel, input bit we, input int wr, input logic [63:0] wd,
                         input bit jal, input logic [63:0] pc);
        if (sel) begin
            we_b = we; wr_b = 4'(wr); wd_b = wd; jal_b = jal; pc_b = pc;
        end else begin
            we_a = we; wr_a = 5'(wr); wd_a = wd[31:0]; jal_a = jal; pc_a = pc[31:0];
        end
    endtask

    task automatic set_rd(input bit sel, input int k, input int idx);
        if (sel) rr_b[k*4 +: 4] = 4'(idx);
        else     rr_a[k*5 +: 5] = 5'(idx);
    endtask

    task automatic set_rst(input bit sel, input logic v);
        if (sel) rst_b = v;
        else     rst_a = v;
    endtask

    // One write cycle: check the bypassed value before the edge and the
    // stored value after it, then fold the write into the model.
    task automatic write_cycle(input bit sel, input bit we, input int wr, input logic [63:0] wd,
                               input bit jal, input logic [63:0] pc, input int k, input int idx,
                               input logic [63:0] exp, input string tag);
        @(negedge clock);
        drive(sel, we, wr, wd, jal, pc);
        set_rd(sel, k, idx);
        #1;
        push({tag, "_pre"}, exp);
        check(lane(sel, k));
        @(posedge clock);
        #1;
        if (jal) mdl[sel][link_idx(sel)] = (pc + 64'd1) & mask(sel);
        if (we && wr != 0) mdl[sel][wr] = wd & mask(sel);
        drive(sel, 1'b0, 0, 64'h0, 1'b0, 64'h0);
        #1;
        push({tag, "_post"}, exp);
        check(lane(sel, k));
    endtask

    task automatic sweep(input bit sel, input string tag);
        @(negedge clock);
        for (int base = 0; base < depth(sel); base += lanes(sel)) begin
            for (int k = 0; k < lanes(sel); k++) set_rd(sel, k, base + k);
            #1;
            for (int k = 0; k < lanes(sel); k++) begin
                push(tag, (base + k == 0) ? 64'h0 : mdl[sel][base + k]);
                check(lane(sel, k));
            end
        end
    endtask

    task automatic hold_reset(input bit sel);
        @(negedge clock);
        set_rst(sel, 1'b0);
        set_rd(sel, 0, 3);
        repeat (3) @(negedge clock);
        push("reset_ready_low", 64'h0);
        check({63'b0, ready(sel)});
        push("reset_lane_zero", 64'h0);
        check(lane(sel, 0));
        set_rst(sel, 1'b1);
    endtask

    // Counts edges after release until flag_ready (bounded by limit); lane 0
    // watches r3, which is poked with a write and a link at edge poke_at.
    task automatic run_clear(input bit sel, input int limit, input int poke_at, output int n);
        n = 0;
        set_rd(sel, 0, 3);
        while (n < limit && !ready(sel)) begin
            @(posedge clock);
            #1;
            n++;
            push("clear_lane_zero", 64'h0);
            check(lane(sel, 0));
            if (n == poke_at) drive(sel, 1'b1, 3, 64'h55, 1'b1, 64'h100);
            else              drive(sel, 1'b0, 0, 64'h0, 1'b0, 64'h0);
        end
        drive(sel, 1'b0, 0, 64'h0, 1'b0, 64'h0);
    endtask

    task automatic run_bank(input bit sel);
        int          n;
        int          wr;
        int          idx;
        int          k;
        bit          we;
        bit          jal;
        logic [63:0] wd;
        logic [63:0] pc;

        hold_reset(sel);
        run_clear(sel, 12, 0, n);
        push("midclear_edges", 64'd12);
        check(64'(n));
        set_rst(sel, 1'b0);
        #1;
        push("midclear_reset_ready", 64'h0);
        check({63'b0, ready(sel)});
        repeat (2) @(negedge clock);
        set_rst(sel, 1'b1);
        // one edge leaves reset, then DEPTH clearing edges
        run_clear(sel, 100, 10, n);
        push("clear_edges", 64'(depth(sel) + 1));
        check(64'(n));
        push("ready_high", 64'h1);
        check({63'b0, ready(sel)});
        sweep(sel, "post_clear_zero");

        if (!sel) begin
            write_cycle(0, 1, 5, 64'hDEAD_BEEF, 0, 0, 0, 5, 64'hDEAD_BEEF, "w_r5");
            @(negedge clock);
            set_rd(0, 0, 5);
            set_rd(0, 1, 0);
            #1;
            push("r5_lane0", 64'hDEAD_BEEF); check(lane(0, 0));
            push("r0_lane1", 64'h0);         check(lane(0, 1));
            write_cycle(0, 1, 0, 64'h1234, 0, 0, 0, 0, 64'h0, "w_r0");
            write_cycle(0, 1, 7, 64'hA5A5_A5A5, 0, 0, 1, 7, 64'hA5A5_A5A5, "bypass_r7");
            write_cycle(0, 0, 0, 0, 1, 64'h40, 0, 31, 64'h41, "link");
            write_cycle(0, 1, 31, 64'h77, 1, 64'h40, 0, 31, 64'h77, "link_collide");
            write_cycle(0, 0, 0, 0, 1, 64'hFFFF_FFFF, 0, 31, 64'h0, "link_wrap");
        end else begin
            write_cycle(1, 1, 9, 64'h0123_4567_89AB_CDEF, 0, 0, 3, 9,
                        64'h0123_4567_89AB_CDEF, "w64_r9");
            @(negedge clock);
            for (int j = 0; j < 4; j++) set_rd(1, j, 9);
            #1;
            for (int j = 0; j < 4; j++) begin
                push("same_addr_lanes", 64'h0123_4567_89AB_CDEF);
                check(lane(1, j));
            end
            write_cycle(1, 0, 0, 0, 1, 64'h1000, 2, 15, 64'h1001, "link64");
            write_cycle(1, 1, 15, 64'hCAFE, 1, 64'h2000, 1, 15, 64'hCAFE, "link64_collide");
            write_cycle(1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 15, 64'h0, "link64_wrap");
        end

        for (int i = 0; i < 12; i++) begin
            wr  = $urandom_range(0, depth(sel) - 1);
            wd  = {32'($urandom), 32'($urandom)} & mask(sel);
            we  = ($urandom_range(0, 3) != 0);
            jal = ($urandom_range(0, 3) == 0);
            pc  = {32'($urandom), 32'($urandom)} & mask(sel);
            idx = ($urandom_range(0, 1) != 0) ? wr : link_idx(sel);
            k   = $urandom_range(0, lanes(sel) - 1);
            write_cycle(sel, we, wr, wd, jal, pc, k, idx,
                        ref_read(sel, idx, we, wr, wd, jal, pc), "rand_wr");
        end
        sweep(sel, "final_sweep");
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 32; r++) mdl[s][r] = 64'h0;
        rst_a = 1'b0; rr_a = '0; wr_a = '0; wd_a = '0; we_a = 1'b0; pc_a = '0; jal_a = 1'b0;
        rst_b = 1'b0; rr_b = '0; wr_b = '0; wd_b = '0; we_b = 1'b0; pc_b = '0; jal_b = 1'b0;

        run_bank(1'b0);
        run_bank(1'b1);

        if (sb.size() != 0) begin
            total++;
            fails++;
            $error("FAIL scoreboard_leftover: observed %0d pending entries expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
